// File: rtl/legv8_exec_ctrl_if.sv
// Bundle between the LEGv8 datapath and the execute-stage controller.
// Signals: decode/operand inputs, datapath control outputs, ALU result,
// branch decision and the registered NZCV flags.
// Flow control: there is no valid/ready pair. Every input is consumed
// combinationally in the cycle it is presented. en is the only
// qualifier, and it gates the NZCV update at the rising clock edge
// (en=0 means stall/hold).
interface legv8_exec_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             en;
  logic [10:0]      opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] imm;
  logic             reg2loc;
  logic             alusrc;
  logic             memtoreg;
  logic             regwrite;
  logic             memread;
  logic             memwrite;
  logic             branch;
  logic [1:0]       aluop;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             take_branch;
  logic [3:0]       nzcv;

  modport master (
    output en, opcode, op_a, op_b, imm,
    input  reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch,
    input  aluop, alu_ctrl, alu_result, zero, take_branch, nzcv
  );

  modport slave (
    input  en, opcode, op_a, op_b, imm,
    output reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch,
    output aluop, alu_ctrl, alu_result, zero, take_branch, nzcv
  );
endinterface

// File: rtl/legv8_exec_ctrl.sv
// LEGv8 single-cycle execute controller: main decoder, ALU-control
// decoder, 64-bit ALU, branch decision and the NZCV status register.
// Optional build macro EXEC_OUT_REG_EN: when defined, alu_result, zero
// and take_branch are registered (one cycle of latency, always loaded,
// asynchronously cleared by reset=0). When it is undefined they are
// combinational.
module legv8_exec_ctrl #(
  parameter int WIDTH = 64
) (
  input logic               clk,
  input logic               reset,
  legv8_exec_ctrl_if.slave  bus
);
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  // CBZ occupies 0x5A0-0x5A7; only the upper 8 bits identify it.
  localparam logic [7:0]  OP_CBZ_HI = 8'hB4;

  logic             is_r;
  logic             reg2loc_d, alusrc_d, memtoreg_d, regwrite_d;
  logic             memread_d, memwrite_d, branch_d;
  logic [1:0]       aluop_d;
  logic [3:0]       alu_ctrl_d;
  logic [WIDTH-1:0] b_mux;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c, zero_c;
  logic [3:0]       flags_c;
  logic [3:0]       nzcv_d, nzcv_q;

  assign is_r = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                (bus.opcode == OP_AND) || (bus.opcode == OP_ORR);

  // Main decoder: unknown opcodes fall through to an all-zero NOP.
  always_comb begin
    reg2loc_d  = 1'b0;
    alusrc_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    aluop_d    = 2'b00;
    if (is_r) begin
      regwrite_d = 1'b1;
      aluop_d    = 2'b10;
    end else if (bus.opcode == OP_LDUR) begin
      alusrc_d   = 1'b1;
      memtoreg_d = 1'b1;
      regwrite_d = 1'b1;
      memread_d  = 1'b1;
    end else if (bus.opcode == OP_STUR) begin
      reg2loc_d  = 1'b1;
      alusrc_d   = 1'b1;
      memwrite_d = 1'b1;
    end else if (bus.opcode[10:3] == OP_CBZ_HI) begin
      reg2loc_d  = 1'b1;
      branch_d   = 1'b1;
      aluop_d    = 2'b01;
    end
  end

  // ALU-control decoder: R-format selects by opcode, otherwise add or pass-B.
  always_comb begin
    alu_ctrl_d = 4'b0010;
    case (aluop_d)
      2'b01: alu_ctrl_d = 4'b0111;
      2'b10: begin
        case (bus.opcode)
          OP_SUB:  alu_ctrl_d = 4'b0110;
          OP_AND:  alu_ctrl_d = 4'b0000;
          OP_ORR:  alu_ctrl_d = 4'b0001;
          default: alu_ctrl_d = 4'b0010;
        endcase
      end
      default: alu_ctrl_d = 4'b0010;
    endcase
  end

  assign b_mux = alusrc_d ? bus.imm : bus.op_b;
  // The subtract carry-out is the unsigned no-borrow flag (A >= B).
  assign sum_w = {1'b0, bus.op_a} + {1'b0, b_mux};
  assign dif_w = {1'b0, bus.op_a} + {1'b0, ~b_mux} + {{WIDTH{1'b0}}, 1'b1};

  // ALU datapath and carry/overflow for the arithmetic operations.
  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (alu_ctrl_d)
      4'b0000: res_c = bus.op_a & b_mux;
      4'b0001: res_c = bus.op_a | b_mux;
      4'b0010: begin
        res_c = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        v_c   = (bus.op_a[WIDTH-1] == b_mux[WIDTH-1]) &&
                (res_c[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      4'b0110: begin
        res_c = dif_w[WIDTH-1:0];
        c_c   = dif_w[WIDTH];
        v_c   = (bus.op_a[WIDTH-1] != b_mux[WIDTH-1]) &&
                (res_c[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      4'b0111: res_c = b_mux;
      4'b1100: res_c = ~(bus.op_a | b_mux);
      default: res_c = '0;
    endcase
  end

  assign zero_c  = ~|res_c;
  assign flags_c = {res_c[WIDTH-1], zero_c, c_c, v_c};
  assign nzcv_d  = (bus.en && (aluop_d == 2'b10)) ? flags_c : nzcv_q;

  // Status register: captures flags from enabled R-format operations only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nzcv_q <= 4'b0000;
    else        nzcv_q <= nzcv_d;
  end

  assign bus.reg2loc  = reg2loc_d;
  assign bus.alusrc   = alusrc_d;
  assign bus.memtoreg = memtoreg_d;
  assign bus.regwrite = regwrite_d;
  assign bus.memread  = memread_d;
  assign bus.memwrite = memwrite_d;
  assign bus.branch   = branch_d;
  assign bus.aluop    = aluop_d;
  assign bus.alu_ctrl = alu_ctrl_d;
  assign bus.nzcv     = nzcv_q;

`ifdef EXEC_OUT_REG_EN
  logic [WIDTH-1:0] res_q;
  logic             zero_q, take_q;

  // Output stage: loads every cycle regardless of en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      take_q <= 1'b0;
    end else begin
      res_q  <= res_c;
      zero_q <= zero_c;
      take_q <= branch_d & zero_c;
    end
  end

  assign bus.alu_result  = res_q;
  assign bus.zero        = zero_q;
  assign bus.take_branch = take_q;
`else
  assign bus.alu_result  = res_c;
  assign bus.zero        = zero_c;
  assign bus.take_branch = branch_d & zero_c;
`endif
endmodule

// File: tb/tb_legv8_exec_ctrl.sv
// Testbench for legv8_exec_ctrl: directed steps from the test plan
// followed by randomized steps, compared against a behavioural model.
module tb_legv8_exec_ctrl;
  localparam int W = 64;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [3:0] exp_nzcv;

  legv8_exec_ctrl_if #(.WIDTH(W)) bus ();

  legv8_exec_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. Control vector order:
  // {reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]}
  function automatic void model(input logic [10:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] i,
                                output logic [8:0] ctl, output logic [3:0] actl,
                                output logic [W-1:0] res, output logic [3:0] flg,
                                output logic is_r);
    logic [W:0]          wide_u;
    logic signed [W+1:0] wide_s;
    logic                c, v;
    ctl = 9'b0; actl = 4'b0010; res = a + b; c = 1'b0; v = 1'b0; is_r = 1'b0;
    if (op == 11'h458) begin
      ctl = 9'b000100010; is_r = 1'b1; res = a + b;
      wide_u = {1'b0, a} + {1'b0, b};
      c = (wide_u > {1'b0, {W{1'b1}}});
      wide_s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
      v = (wide_s != $signed({{2{res[W-1]}}, res}));
    end else if (op == 11'h658) begin
      ctl = 9'b000100010; is_r = 1'b1; actl = 4'b0110; res = a - b;
      c = (a >= b);
      wide_s = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
      v = (wide_s != $signed({{2{res[W-1]}}, res}));
    end else if (op == 11'h450) begin
      ctl = 9'b000100010; is_r = 1'b1; actl = 4'b0000; res = a & b;
    end else if (op == 11'h550) begin
      ctl = 9'b000100010; is_r = 1'b1; actl = 4'b0001; res = a | b;
    end else if (op == 11'h7C2) begin
      ctl = 9'b011110000; res = a + i;
    end else if (op == 11'h7C0) begin
      ctl = 9'b110001000; res = a + i;
    end else if (op >= 11'h5A0 && op <= 11'h5A7) begin
      ctl = 9'b100000101; actl = 4'b0111; res = b;
    end
    flg = {res[W-1], (res == '0), c, v};
  endfunction

  // Single comparison point
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: apply one instruction between edges, check, optionally clock it.
  task automatic step(input logic [10:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] i, input logic en_v, input bit do_clk);
    logic [8:0]   ctl;
    logic [3:0]   actl, flg;
    logic [W-1:0] res;
    logic         isr;
    bit           clk_now;
    clk_now = do_clk;
`ifdef EXEC_OUT_REG_EN
    clk_now = 1'b1;
`endif
    @(negedge clk);
    bus.opcode = op; bus.op_a = a; bus.op_b = b; bus.imm = i; bus.en = en_v;
    model(op, a, b, i, ctl, actl, res, flg, isr);
    #2;
    chk("ctl", {55'b0, bus.reg2loc, bus.alusrc, bus.memtoreg, bus.regwrite,
                bus.memread, bus.memwrite, bus.branch, bus.aluop}, {55'b0, ctl});
    chk("alu_ctrl", {60'b0, bus.alu_ctrl}, {60'b0, actl});
`ifndef EXEC_OUT_REG_EN
    chk("result", bus.alu_result, res);
    chk("zero", {63'b0, bus.zero}, {63'b0, (res == '0)});
    chk("take_branch", {63'b0, bus.take_branch}, {63'b0, ctl[2] & (res == '0)});
`endif
    if (clk_now) begin
      @(posedge clk);
      #1;
      if (en_v && isr && reset) exp_nzcv = flg;
`ifdef EXEC_OUT_REG_EN
      if (!reset) begin
        res = '0;
        ctl = '0;
      end
      chk("result_q", bus.alu_result, res);
      chk("zero_q", {63'b0, bus.zero}, {63'b0, reset && (res == '0)});
      chk("take_q", {63'b0, bus.take_branch}, {63'b0, ctl[2] & (res == '0)});
`endif
    end
    chk("nzcv", {60'b0, bus.nzcv}, {60'b0, exp_nzcv});
  endtask

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] r;
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = {W{1'b1}};
      2:       r = {1'b0, {(W-1){1'b1}}};
      3:       r = {1'b1, {(W-1){1'b0}}};
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  // Directed then randomized stimulus, final report
  initial begin
    logic [10:0]  op;
    logic [W-1:0] a, b;
    checks = 0; failures = 0; exp_nzcv = 4'b0000;
    reset = 1'b0;
    bus.en = 1'b0; bus.opcode = '0; bus.op_a = '0; bus.op_b = '0; bus.imm = '0;
    #2;
    chk("reset_nzcv", {60'b0, bus.nzcv}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    step(11'h458, 64'd5, 64'd7, 64'd0, 1'b1, 1'b1);
    chk("add_result_plan", {60'b0, exp_nzcv}, 64'd0);
    step(11'h658, 64'h10, 64'h10, 64'd0, 1'b1, 1'b1);
    step(11'h658, 64'd0, 64'd1, 64'd0, 1'b1, 1'b1);
    step(11'h7C2, 64'h100, 64'd0, 64'd8, 1'b1, 1'b1);
    step(11'h7C0, 64'h100, 64'd4, 64'd8, 1'b1, 1'b1);
    step(11'h5A3, 64'd9, 64'd0, 64'd0, 1'b1, 1'b0);
    step(11'h5A3, 64'd9, 64'd3, 64'd0, 1'b1, 1'b0);
    step(11'h450, 64'hF0F0, 64'h0FF0, 64'd0, 1'b1, 1'b1);
    step(11'h550, 64'hF000, 64'h000F, 64'd0, 1'b1, 1'b1);
    step(11'h458, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1);
    // en=0 must hold the flags
    step(11'h658, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1);
    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    exp_nzcv = 4'b0000;
    chk("async_reset_nzcv", {60'b0, bus.nzcv}, 64'd0);
`ifdef EXEC_OUT_REG_EN
    chk("async_reset_result", bus.alu_result, 64'd0);
`endif
    // No update on an edge while reset is low
    step(11'h658, 64'd0, 64'd1, 64'd0, 1'b1, 1'b1);
    #1 reset = 1'b1;
    step(11'h000, 64'd3, 64'd4, 64'd5, 1'b1, 1'b1);
    step(11'h5A7, 64'd1, 64'd0, 64'd0, 1'b1, 1'b1);
    step(11'h5A8, 64'd1, 64'd0, 64'd0, 1'b1, 1'b1);

    for (int n = 0; n < 300; n++) begin
      a = rnd64();
      b = rnd64();
      case ($urandom_range(0, 9))
        0: op = 11'h458;
        1: op = 11'h658;
        2: op = 11'h450;
        3: op = 11'h550;
        4: op = 11'h7C2;
        5: op = 11'h7C0;
        6: op = 11'h5A0 | 11'($urandom_range(0, 7));
        7: op = 11'($urandom_range(0, 2047));
        8: begin op = 11'h5A0 | 11'($urandom_range(0, 7)); b = '0; end
        default: begin op = 11'h658; b = a; end
      endcase
      step(op, a, b, rnd64(), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/legv8_exec_ctrl.md
Name: legv8_exec_ctrl

Overview:
Combined main decoder, ALU-control decoder and 64-bit ALU for the single-cycle LEGv8 CPU. It decodes the 11-bit opcode (instr[31:21]) into datapath control signals and a 4-bit ALU operation. It selects ALU operand B between register data and the sign-extended immediate, then produces the result, the zero flag and the branch-taken decision. A clocked NZCV status register holds flags from the most recent R-format operation.

Parameters:
- WIDTH, 64, datapath width of operands and result.

Ports:
- clk  in  1  rising-edge clock, used only by the status register.
- reset  in  1  asynchronous, active-low; 0 clears the status register.
- en  in  1  status-register update enable; 0 holds (stall).
- opcode  in  11  instr[31:21].
- op_a  in  WIDTH  register read data 1.
- op_b  in  WIDTH  register read data 2.
- imm  in  WIDTH  sign-extended immediate.
- reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch  out  1 each  datapath controls.
- aluop  out  2  {ALUOp1, ALUOp0}.
- alu_ctrl  out  4  decoded ALU operation.
- alu_result  out  WIDTH  ALU output.
- zero  out  1  1 when alu_result == 0.
- take_branch  out  1  branch & zero.
- nzcv  out  4  registered flags {N,Z,C,V}.

Behaviour:
- Decoder is purely combinational; opcode matching uses exact 11-bit compares.
- Opcodes:
  - ADD = 0x458
  - SUB = 0x658
  - AND = 0x450
  - ORR = 0x550
  - LDUR = 0x7C2
  - STUR = 0x7C0
  - CBZ = 0x5A0–0x5A7 (low 3 bits are don't-care)
- Control outputs, listed as reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop:
  - R-format (ADD/SUB/AND/ORR): 0,0,0,1,0,0,0,10
  - LDUR: 0,1,1,1,1,0,0,00
  - STUR: 1,1,0,0,0,1,0,00
  - CBZ: 1,0,0,0,0,0,1,01
  - Any other opcode: all outputs 0, aluop 00. A NOP: no register or memory writes, no branch.
- ALU control:
  - aluop 00 -> 0010 (add).
  - aluop 01 -> 0111 (pass B).
  - aluop 10 -> by opcode: ADD 0010, SUB 0110, AND 0000, ORR 0001. Any other opcode -> 0010.
  - aluop 11 -> 0010.
- ALU operand B = alusrc ? imm : op_b.
- ALU operations:
  - 0000: A & B
  - 0001: A | B
  - 0010: A + B
  - 0110: A − B
  - 0111: B
  - 1100: ~(A | B)
  - Other codes: result 0.
- Arithmetic is modulo 2^WIDTH.
- Zero flag: zero = ~|alu_result; take_branch = branch & zero.
- Combinational latency: zero cycles from opcode/operands to all outputs except nzcv.
- Status register, flags from the current operation:
  - N = result[WIDTH-1]
  - Z = zero
  - C = carry-out for add, or no-borrow (A >= B unsigned) for sub
  - V = signed overflow for add/sub
  - C and V are 0 for logic and pass ops.
- nzcv update: at rising clk when en=1 and aluop==10, nzcv <= current flags. Otherwise it holds.
- reset=0 forces nzcv=0000 immediately, regardless of clk or en. Release is synchronous to the next edge; no update occurs on an edge where reset=0.
- All other outputs are unaffected by reset.

Optional Feature:
- Macro EXEC_OUT_REG_EN.
- Defined: alu_result, zero and take_branch are registered on rising clk (1-cycle latency, always loaded, not gated by en). reset=0 asynchronously clears them to 0.
- Undefined: these outputs are combinational as above.
- Decoder outputs and nzcv behave identically in both builds.

Test Plan:
- Opcode 0x458, op_a=5, op_b=7 -> regwrite=1, aluop=10, alu_ctrl=0010, alu_result=12, zero=0. After one clk with en=1, nzcv=0000.
- Opcode 0x658, op_a=op_b=0x10 -> alu_ctrl=0110, result=0, zero=1. After clk, nzcv=0110 (Z,C). Then op_a=0, op_b=1 -> result=0xFFFF_FFFF_FFFF_FFFF; after clk, nzcv=1000.
- Opcode 0x7C2, op_a=0x100, imm=8 -> alusrc=1, memread=1, memtoreg=1, result=0x108. Opcode 0x7C0 -> memwrite=1, reg2loc=1, regwrite=0. nzcv unchanged.
- Opcode 0x5A3, op_b=0 -> branch=1, alu_ctrl=0111, zero=1, take_branch=1. With op_b=3 -> take_branch=0.
- ADD with op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=1 -> after clk, nzcv=1001. Assert reset=0 between edges -> nzcv=0000 immediately. Opcode 0x000 -> all controls 0.
- With EXEC_OUT_REG_EN: ADD 2+3 -> alu_result=5 appears one clk later. reset=0 clears it immediately.
